// File: rtl/hex_scan_driver_if.sv
// Bus between the hex display controller and the scan driver: eight digit
// values plus enable mask toward the driver, segment/anode lines back out.
interface hex_scan_driver_if;
  logic [3:0] hex0_i;
  logic [3:0] hex1_i;
  logic [3:0] hex2_i;
  logic [3:0] hex3_i;
  logic [3:0] hex4_i;
  logic [3:0] hex5_i;
  logic [3:0] hex6_i;
  logic [3:0] hex7_i;
  logic [7:0] bitmask_i;
  logic [6:0] hex_led_o;
  logic [7:0] hex_sel_o;

  // Controller side: supplies digits and mask, observes display lines.
  modport master (
    output hex0_i, hex1_i, hex2_i, hex3_i,
    output hex4_i, hex5_i, hex6_i, hex7_i,
    output bitmask_i,
    input  hex_led_o, hex_sel_o
  );

  // Scan driver side: consumes digits and mask, drives display lines.
  modport slave (
    input  hex0_i, hex1_i, hex2_i, hex3_i,
    input  hex4_i, hex5_i, hex6_i, hex7_i,
    input  bitmask_i,
    output hex_led_o, hex_sel_o
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver for an eight-digit seven-segment display.
// Each digit owns a slot of DIGIT_CYCLES clocks; the first BLANK_CYCLES of a
// slot are dark to suppress ghosting. Segments and anodes are active-low and
// registered, so outputs lag the slot counters and inputs by one cycle.
module hex_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hex_scan_driver_if.slave   bus
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [6:0]       r_led;
  logic [7:0]       r_sel;

  logic             w_blank;
  logic             w_lit;
  logic [3:0]       w_hex;
  logic [6:0]       w_seg;
  logic [7:0]       w_sel_nxt;
  logic [6:0]       w_led_nxt;

  // Blank window exists only when BLANK_CYCLES is non-zero; a zero-width
  // window would otherwise be an always-false unsigned compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (32'(r_cnt) < BLANK_CYCLES);
    end
  endgenerate

  // Select the digit value belonging to the current slot.
  always_comb begin
    w_hex = '0;
    case (r_idx)
      3'd0:    w_hex = bus.hex0_i;
      3'd1:    w_hex = bus.hex1_i;
      3'd2:    w_hex = bus.hex2_i;
      3'd3:    w_hex = bus.hex3_i;
      3'd4:    w_hex = bus.hex4_i;
      3'd5:    w_hex = bus.hex5_i;
      3'd6:    w_hex = bus.hex6_i;
      default: w_hex = bus.hex7_i;
    endcase
  end

  // Hex to active-low gfedcba segment pattern.
  always_comb begin
    w_seg = '1;
    case (w_hex)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

  // Next output load: dark during blanking or for a masked digit, otherwise
  // exactly one anode low with its decoded segments.
  always_comb begin
    w_lit     = !w_blank && bus.bitmask_i[r_idx];
    w_sel_nxt = '1;
    w_led_nxt = '1;
    if (w_lit) begin
      w_sel_nxt = ~(8'b1 << r_idx);
      w_led_nxt = w_seg;
    end
  end

  // Slot counter and digit index; idx advances on the same edge cnt wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered display outputs; reset forces everything dark.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel <= '1;
      r_led <= '1;
    end else begin
      r_sel <= w_sel_nxt;
      r_led <= w_led_nxt;
    end
  end

  assign bus.hex_sel_o = r_sel;
  assign bus.hex_led_o = r_led;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver: one instance with an 8-cycle slot
// and 2-cycle blank, one with a 2-cycle slot and no blanking, both sharing
// clock, reset and inputs, compared every cycle against a reference model.
module tb_hex_scan_driver;

  logic       clk;
  logic       rst;
  logic [3:0] r_hx [8];
  logic [7:0] r_mask;

  int unsigned n_checks;
  int unsigned n_pass;

  hex_scan_driver_if b0 ();
  hex_scan_driver_if b1 ();

  assign b0.hex0_i = r_hx[0];
  assign b0.hex1_i = r_hx[1];
  assign b0.hex2_i = r_hx[2];
  assign b0.hex3_i = r_hx[3];
  assign b0.hex4_i = r_hx[4];
  assign b0.hex5_i = r_hx[5];
  assign b0.hex6_i = r_hx[6];
  assign b0.hex7_i = r_hx[7];
  assign b0.bitmask_i = r_mask;
  assign b1.hex0_i = r_hx[0];
  assign b1.hex1_i = r_hx[1];
  assign b1.hex2_i = r_hx[2];
  assign b1.hex3_i = r_hx[3];
  assign b1.hex4_i = r_hx[4];
  assign b1.hex5_i = r_hx[5];
  assign b1.hex6_i = r_hx[6];
  assign b1.hex7_i = r_hx[7];
  assign b1.bitmask_i = r_mask;

  hex_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b0.slave)
  );

  hex_scan_driver #(.DIGIT_CYCLES(2), .BLANK_CYCLES(0)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[h];
  endfunction

  // Output expected after the n-th non-reset edge following reset, for a
  // display with slot length d and blank length b: {sel, led}.
  function automatic logic [14:0] expect_of(input int unsigned n, input int unsigned d,
                                            input int unsigned b, input logic [7:0] m,
                                            input logic [31:0] hx);
    int unsigned slot;
    int unsigned pos;
    logic [7:0]  one;
    slot = (n / d) % 8;
    pos  = n % d;
    if (pos < b || !m[slot]) return {8'hFF, 7'h7F};
    one = 8'h01 << slot;
    return {~one, seg_of(hx[slot*4 +: 4])};
  endfunction

  int unsigned m_n;
  logic        m_valid;
  logic [14:0] e8;
  logic [14:0] e2;

  initial begin
    m_valid = 1'b0;
    m_n     = 0;
    e8      = '1;
    e2      = '1;
  end

  // Reference model: advance on each edge using the inputs seen at that edge.
  always @(posedge clk) begin
    logic [31:0] hxp;
    hxp = {r_hx[7], r_hx[6], r_hx[5], r_hx[4], r_hx[3], r_hx[2], r_hx[1], r_hx[0]};
    if (rst) begin
      m_valid = 1'b1;
      m_n     = 0;
      e8      = {8'hFF, 7'h7F};
      e2      = {8'hFF, 7'h7F};
    end else if (m_valid) begin
      e8  = expect_of(m_n, 8, 2, r_mask, hxp);
      e2  = expect_of(m_n, 2, 0, r_mask, hxp);
      m_n = m_n + 1;
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("d8_sel", 32'(b0.hex_sel_o), 32'(e8[14:7]));
      check("d8_led", 32'(b0.hex_led_o), 32'(e8[6:0]));
      check("d2_sel", 32'(b1.hex_sel_o), 32'(e2[14:7]));
      check("d2_led", 32'(b1.hex_led_o), 32'(e2[6:0]));
      check("d2_sel_onehot", 32'($countones(~b1.hex_sel_o) <= 1), 32'd1);
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    r_mask   = 8'hFF;
    for (int i = 0; i < 8; i++) r_hx[i] = 4'h0;

    // Reset held three cycles, then release with all-zero digits.
    repeat (3) begin
      @(negedge clk);
      check("rst_sel", 32'(b0.hex_sel_o), 32'hFF);
      check("rst_led", 32'(b0.hex_led_o), 32'h7F);
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 2 || k == 9) begin
        check("rel_dark_sel", 32'(b0.hex_sel_o), 32'hFF);
        check("rel_dark_led", 32'(b0.hex_led_o), 32'h7F);
      end else begin
        check("rel_lit_sel", 32'(b0.hex_sel_o), 32'hFE);
        check("rel_lit_led", 32'(b0.hex_led_o), 32'h40);
      end
    end

    // Full decode of 8..F across two frames.
    for (int i = 0; i < 8; i++) r_hx[i] = 4'(i + 8);
    repeat (128) @(negedge clk);

    // Partial mask, then fully dark mask.
    r_mask = 8'hA5;
    repeat (64) @(negedge clk);
    r_mask = 8'h00;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("mask0_sel", 32'(b0.hex_sel_o), 32'hFF);
    end
    r_mask = 8'hFF;

    // Digit 2 value changes mid lit phase.
    r_hx[2] = 4'h3;
    pulse_reset();
    repeat (20) @(negedge clk);
    check("mid_led_before", 32'(b0.hex_led_o), 32'h30);
    check("mid_sel_before", 32'(b0.hex_sel_o), 32'hFB);
    r_hx[2] = 4'h7;
    @(negedge clk);
    check("mid_led_after", 32'(b0.hex_led_o), 32'h78);
    check("mid_sel_after", 32'(b0.hex_sel_o), 32'hFB);

    // Reset in slot 5, slot cycle 4.
    pulse_reset();
    repeat (44) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(b0.hex_sel_o), 32'hFF);
    check("midrst_led", 32'(b0.hex_led_o), 32'h7F);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_sel", 32'(b0.hex_sel_o), 32'hFE);

    // Randomized digits, mask and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) r_hx[$urandom_range(7)] = 4'($urandom);
      if ($urandom_range(15) == 0) r_mask = 8'($urandom);
      rst = ($urandom_range(299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
